// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU opcodes, branch condition codes and flag bit positions shared across the CPU.
package cpu_pkg;
    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_XOR    = 3'b010;
    localparam logic [2:0] ALU_RED    = 3'b011;
    localparam logic [2:0] ALU_SLL    = 3'b100;
    localparam logic [2:0] ALU_SRA    = 3'b101;
    localparam logic [2:0] ALU_ROR    = 3'b110;
    localparam logic [2:0] ALU_PADDSB = 3'b111;

    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GE     = 3'b100;
    localparam logic [2:0] CC_LE     = 3'b101;
    localparam logic [2:0] CC_OV     = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {ST_IDLE, ST_WAIT} br_state_e;

    // Which of {N,Z,V} an EX instruction is allowed to write.
    function automatic logic [2:0] flag_mask(input logic set_flags, input logic [2:0] op);
        return !set_flags ? 3'b000 :
               (op == ALU_ADD || op == ALU_SUB) ? 3'b111 :
               (op == ALU_RED || op == ALU_PADDSB) ? 3'b000 : 3'b010;
    endfunction
endpackage

// File: rtl/cond_eval.sv
// cond_eval: evaluates a branch condition code against an {N,Z,V} flag vector.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       cond_true
);
    logic n, z, v;
    always_comb begin
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        v = flags[FLAG_V];
        cond_true = (cond == CC_NE) ? !z :
                    (cond == CC_EQ) ? z :
                    (cond == CC_GT) ? (!z && !n) :
                    (cond == CC_LT) ? n :
                    (cond == CC_GE) ? (z || (!z && !n)) :
                    (cond == CC_LE) ? (n || z) :
                    (cond == CC_OV) ? v : 1'b1;
    end
endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural N/Z/V register plus branch resolution,
// covering the EX->ID flag hazard by bypass or by a one-cycle stall.
module flag_branch_unit
    import cpu_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_commit,
    input  logic        ex_set_flags,
    input  logic [2:0]  ex_alu_op,
    input  logic [15:0] ex_result,
    input  logic        ex_v,
    input  logic        id_br_valid,
    input  logic [2:0]  id_cond,
    input  logic        id_flush,
    output logic        br_taken,
    output logic        br_stall,
    output logic [2:0]  flags
);
    logic [2:0] mask, ex_flags, merged, eff_flags;
    logic       cond_true, stall_req;
    br_state_e  state, state_nxt;

    always_comb begin
        mask = flag_mask(ex_set_flags, ex_alu_op);
        ex_flags = {ex_result[15], ex_result == 16'h0000, ex_v};
        // AND with the mask keeps an X on unused ex_v out of the register.
        merged = (flags & ~mask) | (ex_flags & mask);
        eff_flags = (BYPASS && ex_commit) ? merged : flags;
    end

    cond_eval u_cond_eval (
        .flags     (eff_flags),
        .cond      (id_cond),
        .cond_true (cond_true)
    );

    always_comb begin
        stall_req = !BYPASS && state == ST_IDLE && id_br_valid && !id_flush && |mask;
        state_nxt = stall_req ? ST_WAIT : ST_IDLE;
        br_stall = rst_n && stall_req;
        br_taken = rst_n && id_br_valid && !id_flush && !stall_req && cond_true;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 3'b000;
            state <= ST_IDLE;
        end else begin
            if (ex_commit && |mask) flags <= merged;
            state <= state_nxt;
        end
    end
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed scoreboard bench driving a stall-mode and a
// bypass-mode instance with identical stimulus.
module tb_flag_branch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_commit = 1'b0, ex_set_flags = 1'b0, ex_v = 1'b0;
    logic [2:0]  ex_alu_op = 3'b000;
    logic [15:0] ex_result = 16'h0000;
    logic        id_br_valid = 1'b0, id_flush = 1'b0;
    logic [2:0]  id_cond = 3'b000;
    logic        t0, s0, t1, s1;
    logic [2:0]  f0, f1;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        string      tag;
        logic [2:0] f0;
        logic       s0;
        logic       t0;
        logic [2:0] f1;
        logic       s1;
        logic       t1;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    flag_branch_unit #(.BYPASS(1'b0)) dut_stall (
        .clk(clk), .rst_n(rst_n), .ex_commit(ex_commit), .ex_set_flags(ex_set_flags),
        .ex_alu_op(ex_alu_op), .ex_result(ex_result), .ex_v(ex_v),
        .id_br_valid(id_br_valid), .id_cond(id_cond), .id_flush(id_flush),
        .br_taken(t0), .br_stall(s0), .flags(f0)
    );

    flag_branch_unit #(.BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .ex_commit(ex_commit), .ex_set_flags(ex_set_flags),
        .ex_alu_op(ex_alu_op), .ex_result(ex_result), .ex_v(ex_v),
        .id_br_valid(id_br_valid), .id_cond(id_cond), .id_flush(id_flush),
        .br_taken(t1), .br_stall(s1), .flags(f1)
    );

    task automatic cmp(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] ef0, input logic es0, input logic et0,
                              input logic [2:0] ef1, input logic es1, input logic et1);
        exp_t e;
        e.tag = tag; e.f0 = ef0; e.s0 = es0; e.t0 = et0; e.f1 = ef1; e.s1 = es1; e.t1 = et1;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        cmp({e.tag, ".stall_mode.flags"}, f0, e.f0);
        cmp({e.tag, ".stall_mode.br_stall"}, {2'b00, s0}, {2'b00, e.s0});
        cmp({e.tag, ".stall_mode.br_taken"}, {2'b00, t0}, {2'b00, e.t0});
        cmp({e.tag, ".bypass_mode.flags"}, f1, e.f1);
        cmp({e.tag, ".bypass_mode.br_stall"}, {2'b00, s1}, {2'b00, e.s1});
        cmp({e.tag, ".bypass_mode.br_taken"}, {2'b00, t1}, {2'b00, e.t1});
    endtask

    task automatic step(input string tag, input logic c, input logic s, input logic [2:0] op,
                        input logic [15:0] r, input logic v, input logic bv, input logic [2:0] cc,
                        input logic fl, input logic [2:0] ef0, input logic es0, input logic et0,
                        input logic [2:0] ef1, input logic es1, input logic et1);
        @(negedge clk);
        ex_commit = c; ex_set_flags = s; ex_alu_op = op; ex_result = r; ex_v = v;
        id_br_valid = bv; id_cond = cc; id_flush = fl;
        expect_out(tag, ef0, es0, et0, ef1, es1, et1);
        #1;
        check_out();
    endtask

    initial begin
        #3;
        expect_out("reset", 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        //    tag             c     s     op      result    v     bv    cc      fl     f0      s0    t0    f1      s1    t1
        step("eq_none",      1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        step("uncond",       1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1);
        step("sub_zero",     1'b1, 1'b1, 3'b001, 16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        step("eq_after_sub", 1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 3'b001, 1'b0, 3'b010, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1);
        step("add_ov",       1'b1, 1'b1, 3'b000, 16'h8000, 1'b1, 1'b1, 3'b110, 1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1);
        step("ov_wait",      1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 3'b110, 1'b0, 3'b101, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1);
        step("xor_zero",     1'b1, 1'b1, 3'b010, 16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b101, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0);
        step("xor_nz_eq",    1'b1, 1'b1, 3'b010, 16'h0001, 1'bx, 1'b1, 3'b001, 1'b0, 3'b111, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0);
        step("flush_wait",   1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 3'b111, 1'b1, 3'b101, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0);
        step("paddsb",       1'b1, 1'b1, 3'b111, 16'h0000, 1'bx, 1'b1, 3'b001, 1'b0, 3'b101, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0);
        step("idle_uncond",  1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 3'b111, 1'b0, 3'b101, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("held_sub",  1'b0, 1'b1, 3'b001, 16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b101, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0);
        step("sub_commit",   1'b1, 1'b1, 3'b001, 16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b101, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0);
        step("ne",           1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
        step("ge",           1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 3'b100, 1'b0, 3'b010, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1);
        step("le",           1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 3'b101, 1'b0, 3'b010, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1);
        step("gt",           1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 3'b010, 1'b0, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
        step("add_lt",       1'b1, 1'b1, 3'b000, 16'h8000, 1'b1, 1'b1, 3'b011, 1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1);
        step("lt_wait",      1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 3'b011, 1'b0, 3'b101, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        expect_out("async_reset", 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        #1;
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        step("sub_eq_bypass", 1'b1, 1'b1, 3'b001, 16'h0000, 1'b0, 1'b1, 3'b001, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
        step("eq_wait",       1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 3'b001, 1'b0, 3'b010, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
